// File: rtl/prco_led_arbiter.sv
// Purpose: owns the 8-bit LED bank; round-robin share between CPU and debug writers, idle heartbeat, halt blink.
// Latency: 1 cycle from a sampled request to its ack pulse and the new LEDS value.
// Backpressure: requests are level-held until ack; hold window, halt and the halt-exit cycle stall acceptance.
//
// Ports:
//   clk50            system clock (50 MHz)
//   rst              synchronous reset, active-high
//   cpu_req/cpu_data CPU write request (level) and LED value; cpu_ack one-cycle accept pulse
//   dbg_req/dbg_data debug write request (level) and LED value; dbg_ack one-cycle accept pulse
//   halt             core halted (level); forces the full-bank blink
//   busy             hold window active
//   LEDS             LED pins
module prco_led_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int IDLE_CYCLES = 1000,
    parameter int BEAT_CYCLES = 50
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic [7:0] cpu_data,
    output logic       cpu_ack,
    input  logic       dbg_req,
    input  logic [7:0] dbg_data,
    output logic       dbg_ack,
    input  logic       halt,
    output logic       busy,
    output logic [7:0] LEDS
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int IW = $clog2(IDLE_CYCLES);
    localparam int BW = $clog2(BEAT_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        SHOW = 2'd0,
        BEAT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    shadow;     // last accepted value, restored when halt clears
    logic [7:0]    pattern;    // heartbeat pattern, kept across BEAT visits
    logic          rr_dbg;     // 1: debug wins the next tie
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] idle_cnt;
    logic [BW-1:0] beat_cnt;

    logic          accept;
    logic          grant_cpu;
    logic [7:0]    grant_data;
    logic          beat_wrap;
    logic [7:0]    pattern_rot;

    // Halt in the current cycle blocks acceptance even before the FSM reaches HALT.
    assign accept      = (state != HALT) && !halt && (hold_cnt == '0) && (cpu_req || dbg_req);
    assign grant_cpu   = cpu_req && (!dbg_req || !rr_dbg);
    assign grant_data  = grant_cpu ? cpu_data : dbg_data;
    assign beat_wrap   = (beat_cnt == BEAT_LAST);
    assign pattern_rot = {pattern[6:0], pattern[7]};
    assign busy        = (hold_cnt != '0);

    always_ff @(posedge clk50) begin
        if (rst) begin
            state    <= SHOW;
            LEDS     <= 8'h00;
            shadow   <= 8'h00;
            pattern  <= 8'h01;
            rr_dbg   <= 1'b0;
            cpu_ack  <= 1'b0;
            dbg_ack  <= 1'b0;
            hold_cnt <= '0;
            idle_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;

            // Hold window runs in every state, including HALT.
            if (accept)
                hold_cnt <= HOLD_LOAD;
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - HW'(1);

            if (halt) begin
                if (state != HALT) begin
                    state    <= HALT;
                    LEDS     <= 8'hFF;
                    beat_cnt <= '0;
                end else if (beat_wrap) begin
                    beat_cnt <= '0;
                    LEDS     <= ~LEDS;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end else if (state == HALT) begin
                // Leaving halt restores the last written value; pending requests go next cycle.
                state    <= SHOW;
                LEDS     <= shadow;
                idle_cnt <= '0;
            end else if (accept) begin
                // Accept outranks an idle timeout landing on the same edge.
                state    <= SHOW;
                LEDS     <= grant_data;
                shadow   <= grant_data;
                cpu_ack  <= grant_cpu;
                dbg_ack  <= !grant_cpu;
                rr_dbg   <= grant_cpu;
                idle_cnt <= '0;
            end else if (state == SHOW) begin
                if (idle_cnt == IDLE_LAST) begin
                    state    <= BEAT;
                    LEDS     <= pattern;
                    beat_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end else begin
                if (beat_wrap) begin
                    beat_cnt <= '0;
                    pattern  <= pattern_rot;
                    LEDS     <= pattern_rot;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prco_led_arbiter.sv
module tb_prco_led_arbiter;

    localparam int HOLD = 4;
    localparam int IDLE = 16;
    localparam int BEAT = 4;

    logic       clk50 = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_ack;
    logic       dbg_req = 1'b0;
    logic [7:0] dbg_data = 8'h00;
    logic       dbg_ack;
    logic       halt = 1'b0;
    logic       busy;
    logic [7:0] LEDS;

    prco_led_arbiter #(
        .HOLD_CYCLES(HOLD),
        .IDLE_CYCLES(IDLE),
        .BEAT_CYCLES(BEAT)
    ) dut (
        .clk50(clk50),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_data(cpu_data),
        .cpu_ack(cpu_ack),
        .dbg_req(dbg_req),
        .dbg_data(dbg_data),
        .dbg_ack(dbg_ack),
        .halt(halt),
        .busy(busy),
        .LEDS(LEDS)
    );

    always #5 clk50 = ~clk50;

    typedef struct packed {
        logic       is_dbg;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input logic d, input logic [7:0] v);
        exp_t e;
        e.is_dbg = d;
        e.data   = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        check8({tag, "_leds"}, LEDS, 8'h00);
        check1({tag, "_cpu_ack"}, cpu_ack, 1'b0);
        check1({tag, "_dbg_ack"}, dbg_ack, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        rst = 1'b0;
    endtask

    // One requester alone: ack next cycle, then wait out the hold window.
    task automatic single(input string tag, input logic d, input logic [7:0] v);
        if (d) begin dbg_req = 1'b1; dbg_data = v; end
        else   begin cpu_req = 1'b1; cpu_data = v; end
        push(d, v);
        tick();
        check1({tag, "_cpu_ack"}, cpu_ack, !d);
        check1({tag, "_dbg_ack"}, dbg_ack, d);
        check8({tag, "_leds"}, LEDS, v);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        ticks(HOLD);
    endtask

    // Coincident requests: winner acked at once, loser exactly after the hold drains.
    task automatic pair(input string tag, input logic [7:0] c, input logic [7:0] d, input logic dbg_first);
        cpu_req = 1'b1; cpu_data = c;
        dbg_req = 1'b1; dbg_data = d;
        if (dbg_first) begin push(1'b1, d); push(1'b0, c); end
        else           begin push(1'b0, c); push(1'b1, d); end
        tick();
        check1({tag, "_first_cpu_ack"}, cpu_ack, !dbg_first);
        check1({tag, "_first_dbg_ack"}, dbg_ack, dbg_first);
        check8({tag, "_first_leds"}, LEDS, dbg_first ? d : c);
        if (dbg_first) dbg_req = 1'b0; else cpu_req = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            tick();
            check1({tag, "_held_off"}, cpu_ack | dbg_ack, 1'b0);
        end
        tick();
        check1({tag, "_second_cpu_ack"}, cpu_ack, dbg_first);
        check1({tag, "_second_dbg_ack"}, dbg_ack, !dbg_first);
        check8({tag, "_second_leds"}, LEDS, dbg_first ? c : d);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        ticks(HOLD);
    endtask

    // Scoreboard: every ack must match the oldest expected grant, in source and LED value.
    always @(negedge clk50) begin
        exp_t e;
        if (cpu_ack || dbg_ack) begin
            if (sb.size() == 0) begin
                check8("unexpected_ack", {6'b0, dbg_ack, cpu_ack}, 8'h00);
            end else begin
                e = sb.pop_front();
                check8("sb_src", {6'b0, dbg_ack, cpu_ack}, e.is_dbg ? 8'h02 : 8'h01);
                check8("sb_leds", LEDS, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p;

        // Reset state
        ticks(2);
        check8("rst_leds", LEDS, 8'h00);
        check1("rst_cpu_ack", cpu_ack, 1'b0);
        check1("rst_dbg_ack", dbg_ack, 1'b0);
        check1("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Single CPU write, latency 1, busy for HOLD cycles
        cpu_req = 1'b1; cpu_data = 8'hA5; push(1'b0, 8'hA5);
        tick();
        check1("t1_ack", cpu_ack, 1'b1);
        check8("t1_leds", LEDS, 8'hA5);
        check1("t1_busy0", busy, 1'b1);
        cpu_req = 1'b0;
        for (int i = 0; i < HOLD - 1; i++) begin
            tick();
            check1("t1_busy", busy, 1'b1);
            check1("t1_ack_pulse", cpu_ack, 1'b0);
        end
        tick();
        check1("t1_busy_end", busy, 1'b0);

        // Round-robin on coincident requests
        do_reset("t2_rst");
        pair("t2_a", 8'h11, 8'h22, 1'b0);
        pair("t2_b", 8'h33, 8'h44, 1'b0);
        single("t2_c", 1'b0, 8'h55);
        pair("t2_d", 8'h66, 8'h77, 1'b1);

        // Requester holding req through its ack cycle
        cpu_req = 1'b1; cpu_data = 8'h5A; push(1'b0, 8'h5A); push(1'b0, 8'h5A);
        tick();
        check1("t6_ack1", cpu_ack, 1'b1);
        for (int i = 0; i < HOLD; i++) begin
            tick();
            check1("t6_no_double", cpu_ack, 1'b0);
        end
        tick();
        check1("t6_ack2", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        ticks(HOLD);

        // Idle timeout into heartbeat, rotation, exit by write, pattern retained
        cpu_req = 1'b1; cpu_data = 8'h0F; push(1'b0, 8'h0F);
        tick();
        check1("t3_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        ticks(IDLE - 1);
        check8("t3_pre_beat", LEDS, 8'h0F);
        tick();
        check8("t3_beat_entry", LEDS, 8'h01);
        p = 8'h01;
        for (int r = 0; r < 9; r++) begin
            ticks(BEAT - 1);
            check8("t3_beat_steady", LEDS, p);
            tick();
            p = {p[6:0], p[7]};
            check8("t3_beat_rot", LEDS, p);
        end
        cpu_req = 1'b1; cpu_data = 8'hC3; push(1'b0, 8'hC3);
        tick();
        check1("t3_exit_ack", cpu_ack, 1'b1);
        check8("t3_exit_leds", LEDS, 8'hC3);
        cpu_req = 1'b0;
        ticks(IDLE - 1);
        check8("t3_show_again", LEDS, 8'hC3);
        tick();
        check8("t3_pattern_kept", LEDS, 8'h02);

        // Halt blink with a pending request
        single("t4_dbg", 1'b1, 8'h3C);
        cpu_req = 1'b1; cpu_data = 8'h99; halt = 1'b1;
        tick();
        check8("t4_halt_ff", LEDS, 8'hFF);
        check1("t4_halt_noack", cpu_ack, 1'b0);
        ticks(BEAT - 1);
        check8("t4_halt_ff_hold", LEDS, 8'hFF);
        tick();
        check8("t4_halt_00", LEDS, 8'h00);
        ticks(BEAT);
        check8("t4_halt_ff2", LEDS, 8'hFF);
        halt = 1'b0; push(1'b0, 8'h99);
        tick();
        check8("t4_restore", LEDS, 8'h3C);
        check1("t4_restore_noack", cpu_ack, 1'b0);
        tick();
        check1("t4_pending_ack", cpu_ack, 1'b1);
        check8("t4_pending_leds", LEDS, 8'h99);
        cpu_req = 1'b0;
        ticks(HOLD);

        // Reset during hold window
        cpu_req = 1'b1; cpu_data = 8'hAA; push(1'b0, 8'hAA);
        tick();
        cpu_req = 1'b0;
        tick();
        check1("t5_in_hold", busy, 1'b1);
        do_reset("t5_hold_rst");
        cpu_req = 1'b1; cpu_data = 8'hBB; push(1'b0, 8'hBB);
        tick();
        check1("t5_hold_cleared_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        ticks(IDLE - 1);
        check8("t5_pre_beat", LEDS, 8'hBB);
        tick();
        check8("t5_pattern_reset", LEDS, 8'h01);
        ticks(BEAT);
        check8("t5_beat_rot", LEDS, 8'h02);

        // Reset during BEAT, then idle timeout from reset
        do_reset("t5_beat_rst");
        ticks(IDLE - 1);
        check8("t5_idle_pre", LEDS, 8'h00);
        tick();
        check8("t5_idle_beat", LEDS, 8'h01);

        // Reset during HALT with a request arriving on the reset edge
        halt = 1'b1;
        tick();
        check8("t5_halt_ff", LEDS, 8'hFF);
        halt = 1'b0; cpu_req = 1'b1; cpu_data = 8'hEE;
        do_reset("t5_halt_rst");
        cpu_req = 1'b0;
        pair("t5_rr_reset", 8'h12, 8'h34, 1'b0);

        check8("sb_empty", 8'(sb.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
